// File: rtl/s444_resp_misr.sv
// s444_resp_misr: MISR compactor for the six s444 core outputs, with a start/busy/done FSM.
// It counts warm-up and run beats and raises a pass/fail verdict against a golden signature.
module s444_resp_misr #(
  parameter int RESP_W = 6,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter int NUM_PAT = 255,
  parameter int WARMUP = 2,
  parameter int CNT_W = 8
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  input  logic [SIG_W-1:0]  golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  pat_count
);
  typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} state_t;
  localparam state_t FIRST = WARMUP > 0 ? WARM : RUN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WARMUP > 0 ? WARMUP - 1 : 0);
  state_t r_state, w_state;
  logic [SIG_W-1:0] r_sig, w_sig, w_misr;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_pass, w_pass;
  assign w_misr = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
  always_comb begin
    w_state = r_state;
    w_sig = r_sig;
    w_cnt = r_cnt;
    w_pass = r_pass;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state = FIRST;
        w_sig = '0;
        w_cnt = '0;
        w_pass = 1'b0;
      end
      WARM: if (resp_valid) begin
        w_state = r_cnt == WLAST ? RUN : WARM;
        w_cnt = r_cnt == WLAST ? '0 : r_cnt + 1'b1;
      end
      RUN: if (resp_valid) begin
        w_state = r_cnt == LAST ? DONE : RUN;
        w_sig = w_misr;
        w_cnt = r_cnt + 1'b1;
        w_pass = r_cnt == LAST && w_misr == golden;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_state <= IDLE;
      r_sig <= '0;
      r_cnt <= '0;
      r_pass <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sig <= w_sig;
      r_cnt <= w_cnt;
      r_pass <= w_pass;
    end
  end
  assign busy = r_state == WARM || r_state == RUN;
  assign done = r_state == DONE;
  assign pass = r_pass;
  assign signature = r_sig;
  assign pat_count = r_cnt;
endmodule
